mmio_bus_fabric: RTL and testbench

//  Parametrised one-master / NUM_SLAVES-slave valid/ready bus fabric between the CPU memory port and BRAM, SDRAM, SPI flash, UART and CLINT.

---
 rtl/mmio_bus_fabric.sv | 211 +++++++++++++++++++++
 tb/tb_mmio_bus_fabric.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric: one-master / NUM_SLAVES-slave valid/ready bus fabric with a registered,
// table-driven address decoder, single-outstanding-transaction tracking, unmapped-address
// faults and a slave timeout.
//
// Ports:
//   clk_i, rst_i    clock; synchronous active-high reset
//   m_valid_i       master request, held until m_ready_o
//   m_addr_i        byte address
//   m_wdata_i       write data
//   m_wstrb_i       byte strobes, all-zero means read
//   m_ready_o       one-cycle completion pulse
//   m_rdata_o       read data, valid with m_ready_o, held until the next completion
//   m_fault_o       completion is a fault (unmapped address or slave timeout)
//   s_valid_o       one-hot request to the selected slave
//   s_addr_o        registered request address, broadcast to all slaves
//   s_wdata_o       registered write data, broadcast
//   s_wstrb_o       registered byte strobes, broadcast
//   s_ready_i       per-slave completion
//   s_rdata_i       per-slave read data, slave i at [i*DATA_W +: DATA_W]
//   fault_addr_o    address of the most recent faulted request
//   fault_cnt_o     saturating count of faulted requests
module mmio_bus_fabric #(
  parameter int unsigned                   NUM_SLAVES     = 4,
  parameter int unsigned                   ADDR_W         = 32,
  parameter int unsigned                   DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000,
                                                             32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = {32'hF000_0000, 32'hF000_0000,
                                                             32'hF000_0000, 32'hF000_0000},
  parameter int unsigned                   TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0]             ERR_RDATA      = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m_valid_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  input  logic [DATA_W/8-1:0]          m_wstrb_i,
  output logic                         m_ready_o,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_fault_o,
  output logic [NUM_SLAVES-1:0]        s_valid_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic [DATA_W/8-1:0]          s_wstrb_o,
  input  logic [NUM_SLAVES-1:0]        s_ready_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
  output logic [ADDR_W-1:0]            fault_addr_o,
  output logic [7:0]                   fault_cnt_o
);

  localparam int unsigned StrbW     = DATA_W / 8;
  localparam int unsigned SelW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned TimerW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TimerW-1:0] TimerLast =
      (TIMEOUT_CYCLES > 0) ? TimerW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q, state_d;
  logic [SelW-1:0]         sel_q, sel_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
  logic [ADDR_W-1:0]       s_addr_q, s_addr_d;
  logic [DATA_W-1:0]       s_wdata_q, s_wdata_d;
  logic [StrbW-1:0]        s_wstrb_q, s_wstrb_d;
  logic                    m_ready_q, m_ready_d;
  logic                    m_fault_q, m_fault_d;
  logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;
  logic [ADDR_W-1:0]       fault_addr_q, fault_addr_d;
  logic [7:0]              fault_cnt_q, fault_cnt_d;

  // Address decode; iterating from the top down lets the lowest matching index win.
  logic            hit;
  logic [SelW-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = SelW'(i);
      end
    end
  end

  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;

  assign sel_ready = s_ready_i[sel_q];
  assign sel_rdata = s_rdata_i[sel_q*DATA_W +: DATA_W];

  logic              flt;
  logic [ADDR_W-1:0] flt_addr;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    timer_d      = timer_q;
    s_valid_d    = s_valid_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wstrb_d    = s_wstrb_q;
    m_ready_d    = 1'b0;
    m_fault_d    = 1'b0;
    m_rdata_d    = m_rdata_q;
    fault_addr_d = fault_addr_q;
    fault_cnt_d  = fault_cnt_q;
    flt          = 1'b0;
    flt_addr     = '0;

    case (state_q)
      StIdle: begin
        if (m_valid_i) begin
          if (hit) begin
            s_addr_d           = m_addr_i;
            s_wdata_d          = m_wdata_i;
            s_wstrb_d          = m_wstrb_i;
            sel_d              = hit_idx;
            timer_d            = '0;
            s_valid_d          = '0;
            s_valid_d[hit_idx] = 1'b1;
            state_d            = StBusy;
          end else begin
            m_ready_d = 1'b1;
            m_fault_d = 1'b1;
            m_rdata_d = ERR_RDATA;
            flt       = 1'b1;
            flt_addr  = m_addr_i;
            state_d   = StResp;
          end
        end
      end

      StBusy: begin
        // A slave answering on the last allowed cycle still completes normally.
        if (sel_ready) begin
          s_valid_d = '0;
          m_ready_d = 1'b1;
          m_rdata_d = sel_rdata;
          state_d   = StResp;
        end else if (TimeoutEn && (timer_q == TimerLast)) begin
          s_valid_d = '0;
          m_ready_d = 1'b1;
          m_fault_d = 1'b1;
          m_rdata_d = ERR_RDATA;
          flt       = 1'b1;
          flt_addr  = s_addr_q;
          state_d   = StResp;
        end else if (TimeoutEn) begin
          timer_d = timer_q + 1'b1;
        end
      end

      // m_ready_o is high for exactly this cycle.
      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    if (flt) begin
      fault_addr_d = flt_addr;
      if (fault_cnt_q != 8'hFF) begin
        fault_cnt_d = fault_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      timer_q      <= '0;
      s_valid_q    <= '0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_wstrb_q    <= '0;
      m_ready_q    <= 1'b0;
      m_fault_q    <= 1'b0;
      m_rdata_q    <= '0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      timer_q      <= timer_d;
      s_valid_q    <= s_valid_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_wstrb_q    <= s_wstrb_d;
      m_ready_q    <= m_ready_d;
      m_fault_q    <= m_fault_d;
      m_rdata_q    <= m_rdata_d;
      fault_addr_q <= fault_addr_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign m_ready_o    = m_ready_q;
  assign m_fault_o    = m_fault_q;
  assign m_rdata_o    = m_rdata_q;
  assign s_valid_o    = s_valid_q;
  assign s_addr_o     = s_addr_q;
  assign s_wdata_o    = s_wdata_q;
  assign s_wstrb_o    = s_wstrb_q;
  assign fault_addr_o = fault_addr_q;
  assign fault_cnt_o  = fault_cnt_q;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Self-checking bench for mmio_bus_fabric: directed scenarios plus randomized transactions,
// checked against a transaction-level model of decode, latency, timeout and fault counting.
module tb_mmio_bus_fabric;

  localparam int unsigned TO  = 16;
  localparam logic [31:0] ERR = 32'hBADD_0BAD;

  // Window table: slave 0 = BRAM, 1 and 3 overlap at 0x2000_0000, 2 = UART.
  localparam logic [127:0] BASE = {32'h2000_0000, 32'h1000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [127:0] MASK = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  logic [31:0] win_base [4] = '{32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000};
  logic [31:0] win_mask [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};

  logic         clk = 1'b0;
  logic         rst;
  logic         m_valid;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready, m_fault;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid, s_wstrb, s_ready;
  logic [31:0]  s_addr, s_wdata, fault_addr;
  logic [127:0] s_rdata;
  logic [7:0]   fault_cnt;

  int unsigned  lat   [4];
  logic [31:0]  sdata [4];
  int unsigned  scnt  [4];
  logic [3:0]   ready_force;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_faddr = 32'h0;
  int          exp_fcnt  = 0;

  always #5 clk = ~clk;

  mmio_bus_fabric #(
    .NUM_SLAVES    (4),
    .ADDR_W        (32),
    .DATA_W        (32),
    .SLAVE_BASE    (BASE),
    .SLAVE_MASK    (MASK),
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERR)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m_valid_i   (m_valid),
    .m_addr_i    (m_addr),
    .m_wdata_i   (m_wdata),
    .m_wstrb_i   (m_wstrb),
    .m_ready_o   (m_ready),
    .m_rdata_o   (m_rdata),
    .m_fault_o   (m_fault),
    .s_valid_o   (s_valid),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_wstrb_o   (s_wstrb),
    .s_ready_i   (s_ready),
    .s_rdata_i   (s_rdata),
    .fault_addr_o(fault_addr),
    .fault_cnt_o (fault_cnt)
  );

  // Slave models: answer lat[i] cycles after s_valid rises; ready_force injects stray readies.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) scnt[i] <= s_valid[i] ? scnt[i] + 1 : 0;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s_ready[i]          = (s_valid[i] && (scnt[i] == lat[i])) || ready_force[i];
      s_rdata[i*32 +: 32] = sdata[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if ((a & win_mask[i]) == win_base[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete master transaction, checked against the model.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input string tag);
    int          idx, exp_lat, cyc;
    bit          exp_flt;
    logic [31:0] exp_rd, exp_sv;
    idx = ref_decode(a);
    if (idx < 0) begin
      exp_lat = 1; exp_flt = 1'b1;
    end else if (lat[idx] < TO) begin
      exp_lat = int'(lat[idx]) + 2; exp_flt = 1'b0;
    end else begin
      exp_lat = TO + 1; exp_flt = 1'b1;
    end
    exp_rd = exp_flt ? ERR : sdata[(idx < 0) ? 0 : idx];
    exp_sv = (idx < 0) ? 32'd0 : (32'd1 << idx);
    if (exp_flt) begin
      exp_faddr = a;
      if (exp_fcnt < 255) exp_fcnt++;
    end

    @(negedge clk);
    m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws;
    step();
    cyc = 1;
    while (!m_ready && cyc < 60) begin
      check({tag, " s_valid busy"}, {28'd0, s_valid}, exp_sv);
      step();
      cyc++;
    end
    m_valid = 1'b0;
    check({tag, " m_ready"}, {31'd0, m_ready}, 32'd1);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " m_fault"}, {31'd0, m_fault}, {31'd0, exp_flt});
    check({tag, " m_rdata"}, m_rdata, exp_rd);
    check({tag, " s_valid resp"}, {28'd0, s_valid}, 32'd0);
    check({tag, " fault_cnt"}, {24'd0, fault_cnt}, exp_fcnt);
    check({tag, " fault_addr"}, fault_addr, exp_faddr);
    if (idx >= 0) begin
      check({tag, " s_addr"}, s_addr, a);
      check({tag, " s_wdata"}, s_wdata, wd);
      check({tag, " s_wstrb"}, {28'd0, s_wstrb}, {28'd0, ws});
    end
    step();
    check({tag, " single pulse"}, {31'd0, m_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    ready_force = '0;
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0; sdata[i] = 32'h1111_1111 * (i + 1);
    end

    // Reset state
    step(); step();
    check("rst m_ready", {31'd0, m_ready}, 32'd0);
    check("rst m_fault", {31'd0, m_fault}, 32'd0);
    check("rst m_rdata", m_rdata, 32'd0);
    check("rst s_valid", {28'd0, s_valid}, 32'd0);
    check("rst s_addr", s_addr, 32'd0);
    check("rst s_wdata", s_wdata, 32'd0);
    check("rst s_wstrb", {28'd0, s_wstrb}, 32'd0);
    check("rst fault_addr", fault_addr, 32'd0);
    check("rst fault_cnt", {24'd0, fault_cnt}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Stray s_ready while idle is ignored
    @(negedge clk); ready_force = 4'hF;
    @(negedge clk); ready_force = 4'h0;
    step();
    check("idle stray ready", {31'd0, m_ready}, 32'd0);

    // BRAM read, ready one cycle after s_valid
    lat[0] = 1; sdata[0] = 32'hDEAD_BEEF;
    run_txn(32'h0000_0100, 32'h0, 4'b0000, "bram read");

    // UART partial write
    lat[2] = 0;
    run_txn(32'h1000_0000, 32'hCAFE_F00D, 4'b0011, "uart write");

    // Unmapped access, first fault
    run_txn(32'hF000_0000, 32'h1234_5678, 4'b1111, "unmapped");
    check("first fault cnt", {24'd0, fault_cnt}, 32'd1);

    // Overlap: slave1 beats slave3
    lat[1] = 2; lat[3] = 0; sdata[1] = 32'hA5A5_0001; sdata[3] = 32'h5A5A_0003;
    run_txn(32'h2000_0000, 32'h0, 4'b0000, "overlap");
    // Slave3-only part of its window
    run_txn(32'h2ABC_0010, 32'h0, 4'b0000, "slave3 only");

    // Ready on the last allowed cycle still wins over the timeout
    lat[0] = TO - 1;
    run_txn(32'h0000_0020, 32'h0, 4'b0000, "edge ready");

    // Timeout, then a late ready that must be dropped
    lat[0] = 1000;
    run_txn(32'h0000_0040, 32'h0, 4'b0000, "timeout");
    step(); step(); step();
    @(negedge clk); ready_force = 4'b0001;
    @(negedge clk); ready_force = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step();
      check("late ready dropped", {31'd0, m_ready}, 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      for (int i = 0; i < 4; i++) begin
        lat[i] = $urandom_range(0, 20); sdata[i] = $urandom;
      end
      case ($urandom_range(0, 5))
        0: a = {16'h0000, 16'($urandom)};
        1: a = {16'h1000, 16'($urandom)};
        2: a = {16'h2000, 16'($urandom)};
        3: a = {4'h2, 28'($urandom)};
        4: a = {4'hF, 28'($urandom)};
        default: a = $urandom;
      endcase
      run_txn(a, $urandom, 4'($urandom), "random");
    end

    // Reset while BUSY aborts silently
    lat[0] = 1000;
    @(negedge clk); m_valid = 1'b1; m_addr = 32'h0000_0080; m_wstrb = 4'b0000;
    step();
    check("pre-reset s_valid", {28'd0, s_valid}, 32'd1);
    step(); step();
    @(negedge clk); rst = 1'b1; m_valid = 1'b0;
    step();
    check("mid-busy rst s_valid", {28'd0, s_valid}, 32'd0);
    check("mid-busy rst m_ready", {31'd0, m_ready}, 32'd0);
    check("mid-busy rst fault_cnt", {24'd0, fault_cnt}, 32'd0);
    exp_fcnt = 0; exp_faddr = 32'h0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("after rst no m_ready", {31'd0, m_ready}, 32'd0);
    end

    // Fault counter saturation
    for (int n = 0; n < 300; n++) begin
      run_txn(32'hF000_0000 + 32'(n * 4), 32'h0, 4'b0000, "sat");
    end
    check("fault_cnt saturated", {24'd0, fault_cnt}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
